cdb_arbiter: RTL and testbench

Writeback arbiter that shares the `CDB_PORTS` common data bus lanes among `NUM_FU` functional units. Each unit gets a one-entry holding buffer, and the arbiter drains the buffers onto the bus in round-robin order. Results that cannot be granted are held, and the unit is back-pressured. The block sits between the FU outputs and the `cdb_rob_ids` inputs of the reservation tables, the ROB and the physical register file.

---
 rtl/rv32i_types.sv | 19 +
 rtl/cdb_rr_select.sv | 49 ++++
 rtl/cdb_arbiter.sv | 91 +++++++++
 tb/tb_cdb_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared core types: ROB/physical-register ids and the FU result bundle.
// fu_output_t is what every FU hands to writeback and what the CDB carries.
package rv32i_types;

  localparam int ROB_IDX_W  = 6;
  localparam int PHYS_IDX_W = 6;

  typedef logic [ROB_IDX_W-1:0]  rob_id_t;
  typedef logic [PHYS_IDX_W-1:0] phys_id_t;

  typedef struct packed {
    logic        ready_for_writeback;
    rob_id_t     rob_id;
    phys_id_t    pd;
    logic [4:0]  rd;
    logic [31:0] rd_v;
  } fu_output_t;

endpackage

// File: rtl/cdb_rr_select.sv
// Combinational round-robin picker: scans from i_rr_ptr, grants the first
// CDB_PORTS full buffers; lane k gets the k-th grant; reports next pointer.
// Ports: i_full, i_rr_ptr -> o_grant, o_lane_idx/o_lane_vld, o_next_ptr.
module cdb_rr_select #(
  parameter int NUM_FU    = 4,
  parameter int CDB_PORTS = 2,
  parameter int PW        = $clog2(NUM_FU)
) (
  input  logic [NUM_FU-1:0]    i_full,
  input  logic [PW-1:0]        i_rr_ptr,
  output logic [NUM_FU-1:0]    o_grant,
  output logic [PW-1:0]        o_lane_idx [CDB_PORTS],
  output logic [CDB_PORTS-1:0] o_lane_vld,
  output logic [PW-1:0]        o_next_ptr
);

  localparam int CW = $clog2(CDB_PORTS + 1);

  logic [PW-1:0] w_idx;
  logic [CW-1:0] w_cnt;

  always_comb begin
    o_grant    = '0;
    o_lane_vld = '0;
    o_next_ptr = i_rr_ptr;
    for (int k = 0; k < CDB_PORTS; k++) begin
      o_lane_idx[k] = '0;
    end
    w_idx = i_rr_ptr;
    w_cnt = '0;
    for (int s = 0; s < NUM_FU; s++) begin
      if (i_full[w_idx] && (w_cnt < CW'(CDB_PORTS))) begin
        o_grant[w_idx] = 1'b1;
        // constant lane index avoids a variable-width array select
        for (int k = 0; k < CDB_PORTS; k++) begin
          if (w_cnt == CW'(k)) begin
            o_lane_idx[k] = w_idx;
            o_lane_vld[k] = 1'b1;
          end
        end
        w_cnt = w_cnt + CW'(1);
        o_next_ptr = (w_idx == PW'(NUM_FU - 1)) ? '0 : w_idx + PW'(1);
      end
      // explicit wrap so non-power-of-two NUM_FU works
      w_idx = (w_idx == PW'(NUM_FU - 1)) ? '0 : w_idx + PW'(1);
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Writeback arbiter: one holding buffer per FU, drained round-robin onto
// CDB_PORTS registered lanes. Ports: clk, rst, flush, fu_result/fu_accept, cdb_out.
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_FU    = 4,
  parameter int CDB_PORTS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  fu_output_t        fu_result [NUM_FU],
  output logic [NUM_FU-1:0] fu_accept,
  output fu_output_t        cdb_out [CDB_PORTS]
);

  localparam int PW = $clog2(NUM_FU);

  logic [NUM_FU-1:0]    r_full;
  fu_output_t           r_data [NUM_FU];
  logic [PW-1:0]        r_rr_ptr;
  fu_output_t           r_cdb [CDB_PORTS];

  logic [NUM_FU-1:0]    w_grant;
  logic [PW-1:0]        w_lane_idx [CDB_PORTS];
  logic [CDB_PORTS-1:0] w_lane_vld;
  logic [PW-1:0]        w_next_ptr;
  logic [NUM_FU-1:0]    w_xfer;

  cdb_rr_select #(
    .NUM_FU    (NUM_FU),
    .CDB_PORTS (CDB_PORTS),
    .PW        (PW)
  ) u_sel (
    .i_full     (r_full),
    .i_rr_ptr   (r_rr_ptr),
    .o_grant    (w_grant),
    .o_lane_idx (w_lane_idx),
    .o_lane_vld (w_lane_vld),
    .o_next_ptr (w_next_ptr)
  );

  // a granted buffer drains this edge, so it can refill in the same cycle
  assign fu_accept = ~r_full | w_grant;

  always_comb begin
    w_xfer = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      w_xfer[i] = fu_result[i].ready_for_writeback & fu_accept[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full   <= '0;
      r_rr_ptr <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        r_data[i] <= '0;
      end
      for (int k = 0; k < CDB_PORTS; k++) begin
        r_cdb[k] <= '0;
      end
    end else if (flush) begin
      r_full <= '0;
      for (int k = 0; k < CDB_PORTS; k++) begin
        r_cdb[k] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (w_xfer[i]) begin
          r_data[i] <= fu_result[i];
          r_full[i] <= 1'b1;
        end else if (w_grant[i]) begin
          r_full[i] <= 1'b0;
        end
      end
      for (int k = 0; k < CDB_PORTS; k++) begin
        if (w_lane_vld[k]) begin
          r_cdb[k] <= r_data[w_lane_idx[k]];
          r_cdb[k].ready_for_writeback <= 1'b1;
        end else begin
          r_cdb[k] <= '0;
        end
      end
      r_rr_ptr <= w_next_ptr;
    end
  end

  assign cdb_out = r_cdb;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: stimulus pushes expected (cycle, lane,
// rob_id) beats; a negedge monitor pops and compares every live lane.
module tb_cdb_arbiter;
  import rv32i_types::*;

  logic       clk;
  logic       rst;
  logic       flush;
  fu_output_t fu_result [4];
  logic [3:0] fu_accept;
  fu_output_t cdb_out [2];

  cdb_arbiter #(.NUM_FU(4), .CDB_PORTS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .fu_result (fu_result),
    .fu_accept (fu_accept),
    .cdb_out   (cdb_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         lane;
    logic [5:0] rob;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   nvec = 0;
  int   nmis = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] val_of(logic [5:0] rob);
    return {26'h0, rob} + 32'h1000;
  endfunction

  // monitor
  always @(negedge clk) begin
    if (!rst) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        exp_t m;
        m = q.pop_front();
        chk("missed_beat", 64'(cyc), 64'(m.cyc));
      end
      for (int k = 0; k < 2; k++) begin
        if (cdb_out[k].ready_for_writeback) begin
          if (q.size() == 0) begin
            chk("unexpected_beat", 64'(cdb_out[k].rob_id), 64'hFF);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("beat_cyc", 64'(cyc), 64'(e.cyc));
            chk("beat_lane", 64'(k), 64'(e.lane));
            chk("beat_rob", 64'(cdb_out[k].rob_id), 64'(e.rob));
            chk("beat_val", 64'(cdb_out[k].rd_v), 64'(val_of(e.rob)));
          end
        end
      end
    end
  end

  function automatic logic [1:0] valids();
    return {cdb_out[1].ready_for_writeback, cdb_out[0].ready_for_writeback};
  endfunction

  task automatic present(int i, logic [5:0] rob);
    fu_result[i] = '0;
    fu_result[i].ready_for_writeback = 1'b1;
    fu_result[i].rob_id = rob;
    fu_result[i].pd = rob;
    fu_result[i].rd = rob[4:0];
    fu_result[i].rd_v = val_of(rob);
  endtask

  task automatic clr_all();
    for (int i = 0; i < 4; i++) fu_result[i] = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int c, int l, logic [5:0] r);
    exp_t e;
    e.cyc = c;
    e.lane = l;
    e.rob = r;
    q.push_back(e);
  endtask

  int         now;
  int         seq [4];
  logic [3:0] acc;
  int         it;

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    clr_all();
    repeat (3) step();
    rst = 1'b0;

    // idle after reset
    for (int c = 0; c < 10; c++) begin
      step();
      chk("idle_accept", 64'(fu_accept), 64'hF);
      chk("idle_valids", 64'(valids()), 64'h0);
    end

    // single FU2 result
    now = cyc;
    present(2, 6'd5);
    push(now + 2, 0, 6'd5);
    step();
    clr_all();
    step();
    chk("single_ptr", 64'(dut.r_rr_ptr), 64'd3);
    step();

    // FU3 alone brings pointer back to 0
    now = cyc;
    present(3, 6'd7);
    push(now + 2, 0, 6'd7);
    step();
    clr_all();
    step();
    chk("wrap_ptr", 64'(dut.r_rr_ptr), 64'd0);
    step();

    // all four at once
    now = cyc;
    for (int i = 0; i < 4; i++) present(i, 6'(10 + i));
    push(now + 2, 0, 6'd10);
    push(now + 2, 1, 6'd11);
    push(now + 3, 0, 6'd12);
    push(now + 3, 1, 6'd13);
    step();
    clr_all();
    chk("all4_accept_a", 64'(fu_accept), 64'b0011);
    step();
    chk("all4_accept_b", 64'(fu_accept), 64'b1111);
    step();
    chk("all4_ptr", 64'(dut.r_rr_ptr), 64'd0);
    step();

    // streaming: every FU always valid, holds until accepted
    now = cyc;
    for (int r = 0; r < 6; r++) begin
      push(now + 2 + 2 * r, 0, 6'(32 + 0 + r));
      push(now + 2 + 2 * r, 1, 6'(32 + 8 + r));
      push(now + 3 + 2 * r, 0, 6'(32 + 16 + r));
      push(now + 3 + 2 * r, 1, 6'(32 + 24 + r));
    end
    for (int i = 0; i < 4; i++) seq[i] = 0;
    it = 0;
    while ((seq[0] < 6 || seq[1] < 6 || seq[2] < 6 || seq[3] < 6) && it < 40) begin
      for (int i = 0; i < 4; i++) begin
        if (seq[i] < 6) present(i, 6'(32 + 8 * i + seq[i]));
        else fu_result[i] = '0;
      end
      acc = fu_accept;
      if (it == 1) chk("stream_acc1", 64'(acc), 64'b0011);
      if (it == 2) chk("stream_acc2", 64'(acc), 64'b1100);
      step();
      for (int i = 0; i < 4; i++) begin
        if (seq[i] < 6 && acc[i]) seq[i]++;
      end
      it++;
    end
    chk("stream_bound", 64'(it < 40), 64'd1);
    clr_all();
    repeat (4) step();
    chk("stream_ptr", 64'(dut.r_rr_ptr), 64'd0);

    // flush with three buffers full and two lanes live
    now = cyc;
    for (int i = 0; i < 4; i++) present(i, 6'(20 + i));
    push(now + 2, 0, 6'd20);
    push(now + 2, 1, 6'd21);
    step();
    clr_all();
    present(0, 6'd50);
    step();
    chk("pre_flush_valids", 64'(valids()), 64'b11);
    clr_all();
    present(1, 6'd51);
    flush = 1'b1;
    step();
    flush = 1'b0;
    clr_all();
    chk("flush_accept", 64'(fu_accept), 64'hF);
    chk("flush_valids", 64'(valids()), 64'h0);
    chk("flush_ptr", 64'(dut.r_rr_ptr), 64'd2);
    repeat (4) step();

    // asynchronous reset mid-cycle with buffers full
    for (int i = 0; i < 4; i++) present(i, 6'(24 + i));
    step();
    clr_all();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_accept", 64'(fu_accept), 64'hF);
    chk("rst_valids", 64'(valids()), 64'h0);
    chk("rst_ptr", 64'(dut.r_rr_ptr), 64'd0);
    step();
    rst = 1'b0;
    repeat (3) step();
    now = cyc;
    present(1, 6'd60);
    push(now + 2, 0, 6'd60);
    step();
    clr_all();
    step();
    chk("post_rst_ptr", 64'(dut.r_rr_ptr), 64'd2);
    repeat (3) step();

    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
